seg7_scan_driver: RTL and testbench

//  Time-multiplexed 4-digit 7-segment display driver. Consumes four BCD digits

---
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed 4-digit common-anode 7-segment scan driver with per-frame double-buffered digits.
// Latency: an/seg/dp are registered one cycle behind cnt/idx/shadow; frame_done pulses the cycle after the 3->0 wrap.
// Backpressure: none, free-running scan; blank gates anodes only. Optional LEADING_ZERO_BLANK_EN hides a zero leftmost digit.
module seg7_scan_driver #(
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 16,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_mask,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Inactive pin levels depend on the board polarity.
    localparam logic [3:0] AN_OFF  = (AN_ACT_LOW  != 0) ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACT_LOW != 0);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_dig;   // {d3,d2,d1,d0} latched at the frame boundary
    logic [3:0]    sh_dp;

    logic          last_cnt;
    logic          frame_end;
    logic [3:0]    cur_dig;
    logic [6:0]    seg_lit;  // logical 1 = segment lit, {g,f,e,d,c,b,a}
    logic [3:0]    an_lit;   // logical 1 = anode on
    logic          lz_hide;

    assign last_cnt  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = last_cnt && (idx == 2'd3);
    assign cur_dig   = sh_dig[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_hide = (idx == 2'd3) && (sh_dig[15:12] == 4'd0);
`else
    assign lz_hide = 1'b0;
`endif

    // BCD to segment decode; non-BCD codes show a dash so bad upstream data is visible.
    always_comb begin
        seg_lit = 7'b1000000;
        case (cur_dig)
            4'd0: seg_lit = 7'b0111111;
            4'd1: seg_lit = 7'b0000110;
            4'd2: seg_lit = 7'b1011011;
            4'd3: seg_lit = 7'b1001111;
            4'd4: seg_lit = 7'b1100110;
            4'd5: seg_lit = 7'b1101101;
            4'd6: seg_lit = 7'b1111101;
            4'd7: seg_lit = 7'b0000111;
            4'd8: seg_lit = 7'b1111111;
            4'd9: seg_lit = 7'b1101111;
            default: seg_lit = 7'b1000000;
        endcase
    end

    // Only the current slot's anode may light, and only after the anti-ghost guard window.
    always_comb begin
        an_lit = 4'b0000;
        if ((cnt >= CW'(GUARD)) && !blank && !lz_hide) begin
            an_lit[idx] = 1'b1;
        end
    end

    // Slot timer, digit index and frame-boundary capture of the display data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            sh_dig     <= 16'h0000;
            sh_dp      <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (last_cnt) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_end) begin
                sh_dig <= {d3, d2, d1, d0};
                sh_dp  <= dp_mask;
            end
        end
    end

    // Registered pin drivers so the pads see glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= (AN_ACT_LOW  != 0) ? ~an_lit  : an_lit;
            seg <= (SEG_ACT_LOW != 0) ? ~seg_lit : seg_lit;
            dp  <= (SEG_ACT_LOW != 0) ? ~sh_dp[idx] : sh_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: SCAN_DIV=8, GUARD=2, active-low anodes and segments.
// A cycle model pushes expected pin values each clock; a checker pops them on the falling edge.
// Directed steps cover reset, scan order, tearing, dash/dp, blanking and leading-zero handling.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
    logic [3:0] dp_mask = 4'd0;
    logic       blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int n_pass  = 0;
    int n_total = 0;

    seg7_scan_driver #(
        .SCAN_DIV(8), .GUARD(2), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_mask(dp_mask), .blank(blank), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Active-low segment pattern for a BCD digit, taken from the decode table.
    function automatic logic [6:0] seg_pin(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'd0: lit = 7'b0111111;
            4'd1: lit = 7'b0000110;
            4'd2: lit = 7'b1011011;
            4'd3: lit = 7'b1001111;
            4'd4: lit = 7'b1100110;
            4'd5: lit = 7'b1101101;
            4'd6: lit = 7'b1111101;
            4'd7: lit = 7'b0000111;
            4'd8: lit = 7'b1111111;
            4'd9: lit = 7'b1101111;
            default: lit = 7'b1000000;
        endcase
        return ~lit;
    endfunction

    // Scoreboard: {an[3:0], seg[6:0], dp, frame_done}
    logic [12:0] sb_q[$];
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [3:0]  m_sh[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  m_dp = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] e_an;
        logic       hide;
        if (!rst_n) begin
            m_cnt = 0;
            m_idx = 0;
            m_sh  = '{4'd0, 4'd0, 4'd0, 4'd0};
            m_dp  = 4'd0;
            sb_q.delete();
        end else begin
            hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            hide = (m_idx == 3) && (m_sh[3] == 4'd0);
`endif
            e_an = 4'b1111;
            if (m_cnt >= 2 && !blank && !hide) e_an[m_idx] = 1'b0;
            sb_q.push_back({e_an, seg_pin(m_sh[m_idx]), ~m_dp[m_idx],
                            (m_cnt == 7 && m_idx == 3)});
            if (m_cnt == 7) begin
                m_cnt = 0;
                if (m_idx == 3) begin
                    m_idx = 0;
                    m_sh[3] = d3; m_sh[2] = d2; m_sh[1] = d1; m_sh[0] = d0;
                    m_dp = dp_mask;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_an", 32'(an), 32'(e[12:9]));
            chk("sb_seg", 32'(seg), 32'(e[8:2]));
            chk("sb_dp", 32'(dp), 32'(e[1]));
            chk("sb_fd", 32'(frame_done), 32'(e[0]));
        end
    end

    task automatic wait_fd(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] v, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an === v) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        int n_on;
        logic [6:0] seg_seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Scan order and slot width
        d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
        wait_fd("fd_first");
        wait_an(4'b1110, "scan_an0");
        chk("scan_seg0", 32'(seg), 32'(7'b0011001));
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== 4'b1110) break;
            n++;
        end
        chk("scan_width", 32'(n), 32'd6);
        chk("scan_guard", 32'(an), 32'h F);

        // Mid-frame change of d0 must wait for the next boundary
        d0 = 4'd9;
        wait_an(4'b1101, "scan_an1");
        chk("scan_seg1", 32'(seg), 32'(7'b0110000));
        wait_an(4'b1011, "scan_an2");
        chk("scan_seg2", 32'(seg), 32'(7'b0100100));
        wait_an(4'b0111, "scan_an3");
        chk("scan_seg3", 32'(seg), 32'(7'b1111001));
        wait_fd("fd_tear");
        wait_an(4'b1110, "tear_an0");
        chk("tear_seg0", 32'(seg), 32'(7'b0010000));

        // Invalid code shows dash; dp only on digit 2
        d1 = 4'hC;
        dp_mask = 4'b0100;
        wait_fd("fd_dash");
        wait_an(4'b1101, "dash_an1");
        chk("dash_seg", 32'(seg), 32'(7'b0111111));
        chk("dash_dp", 32'(dp), 32'd1);
        wait_an(4'b1011, "dp_an2");
        chk("dp_on", 32'(dp), 32'd0);

        // Blank: anodes off, frame timing untouched
        blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("blank_an", 32'(an), 32'h F);
        end
        wait_fd("fd_blank");
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) break;
        end
        chk("blank_period", 32'(n), 32'd32);
        blank = 1'b0;

        // Leading-zero digit 3
        d3 = 4'd0; d2 = 4'd5; dp_mask = 4'd0;
        wait_fd("fd_lz");
        n_on = 0;
        seg_seen = 7'h00;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an[3] === 1'b0) begin
                n_on++;
                seg_seen = seg;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_an3_cycles", 32'(n_on), 32'd0);
`else
        chk("lz_an3_cycles", 32'(n_on), 32'd6);
        chk("lz_seg3", 32'(seg_seen), 32'(7'b1000000));
`endif

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'h F);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'd1);
        chk("arst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_an(4'b1110, "post_rst_an0");
        chk("post_rst_zero", 32'(seg), 32'(7'b1000000));
        wait_fd("fd_post_rst");
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
